// File: rtl/srrc_coef_bank_ctrl_pkg.sv
// ============================================================================
// Module : srrc_pkg
// Brief  : Shared constants, coefficient type and controller state encoding
//          for the folded 199-tap SRRC receive filter coefficient path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package srrc_pkg;

  // Unique (folded) coefficients; index 0 is the outermost tap.
  localparam int NUM_TAPS = 100;
  // Coefficient width, signed 1s17.
  localparam int COEF_W   = 18;
  // Counter / address width, wide enough to hold NUM_TAPS.
  localparam int CNT_W    = 7;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/srrc_coef_bank.sv
// ============================================================================
// Module : srrc_coef_bank
// Brief  : Two-bank coefficient register file. One write port addresses
//          either bank; the bank selected by rd_bank is presented on a
//          registered, flattened output.
//          Optional macro SRRC_COEF_READBACK_EN adds a registered single-word
//          read of the selected bank.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module srrc_coef_bank
  import srrc_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic                       wr_bank,
  input  logic [CNT_W-1:0]           wr_addr,
  input  coef_t                      wr_data,
  input  logic                       rd_bank,
  output logic [COEF_W*NUM_TAPS-1:0] coef_flat
`ifdef SRRC_COEF_READBACK_EN
  ,
  input  logic [CNT_W-1:0]           rd_addr,
  output coef_t                      rd_data
`endif
);

  coef_t                      r_bank0 [NUM_TAPS];
  coef_t                      r_bank1 [NUM_TAPS];
  logic [COEF_W*NUM_TAPS-1:0] r_coef_flat;

  // Storage: only the addressed word of the written bank changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
    end else if (we) begin
      if (wr_bank) r_bank1[wr_addr] <= wr_data;
      else         r_bank0[wr_addr] <= wr_data;
    end
  end

  // Registered mux of the selected bank; follows a bank switch one cycle late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_coef_flat <= '0;
    end else begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_coef_flat[COEF_W*i +: COEF_W] <= rd_bank ? r_bank1[i] : r_bank0[i];
      end
    end
  end

  assign coef_flat = r_coef_flat;

`ifdef SRRC_COEF_READBACK_EN
  coef_t r_rd_data;

  // Single-word readback of the selected bank; addresses past the end read 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (rd_addr < CNT_W'(NUM_TAPS)) begin
      r_rd_data <= rd_bank ? r_bank1[rd_addr] : r_bank0[rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign rd_data = r_rd_data;
`endif

endmodule

`default_nettype wire

// File: rtl/srrc_coef_bank_ctrl.sv
// ============================================================================
// Module : srrc_coef_bank_ctrl
// Brief  : Coefficient bank controller for the folded SRRC receive filter.
//          Streams a full coefficient set into the shadow bank and swaps it
//          live only on a symbol boundary. Length errors and aborts leave
//          the active bank untouched.
//          Optional macro SRRC_COEF_READBACK_EN adds rd_addr / rd_data.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module srrc_coef_bank_ctrl
  import srrc_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sym_clk_en,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [COEF_W-1:0]          wr_data,
  input  logic                       wr_last,
  input  logic                       abort,
  output logic [COEF_W*NUM_TAPS-1:0] coef_flat,
  output logic                       active_bank,
  output logic                       busy,
  output logic                       swap_done,
  output logic                       load_err
`ifdef SRRC_COEF_READBACK_EN
  ,
  input  logic [CNT_W-1:0]           rd_addr,
  output logic [COEF_W-1:0]          rd_data
`endif
);

  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(NUM_TAPS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_wr_addr;
  logic             r_wr_ready;
  logic             r_load_err;
  logic             w_err_nxt;
  logic             r_active_bank;
  logic             r_swap_done;
  logic             w_swap;
  logic             w_we;
  logic             w_xfer;

  // Next-state, write strobe and swap decision; abort outranks transfers and swaps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_load_err;
    w_wr_addr   = r_cnt;
    w_we        = 1'b0;
    w_swap      = 1'b0;
    w_xfer      = wr_valid && r_wr_ready;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_we      = 1'b1;
          w_wr_addr = '0;
          w_cnt_nxt = CNT_W'(1);
          if (wr_last) begin
            // A one-word set is always short with more than one tap.
            w_err_nxt   = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_err_nxt   = 1'b0;
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_xfer) begin
          w_we = 1'b1;
          if (wr_last && (r_cnt == C_LAST_IDX)) begin
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = '0;
          end else if (wr_last || (r_cnt == C_LAST_IDX)) begin
            // Early last, or final index without last: discard this set.
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_ARMED: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (sym_clk_en) begin
          w_swap      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Controller state, counter, handshake and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_wr_ready    <= 1'b0;
      r_load_err    <= 1'b0;
      r_active_bank <= 1'b0;
      r_swap_done   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_wr_ready    <= (w_state_nxt != ST_ARMED);
      r_load_err    <= w_err_nxt;
      r_active_bank <= r_active_bank ^ w_swap;
      r_swap_done   <= w_swap;
    end
  end

  assign wr_ready    = r_wr_ready;
  assign busy        = (r_state != ST_IDLE);
  assign swap_done   = r_swap_done;
  assign load_err    = r_load_err;
  assign active_bank = r_active_bank;

  srrc_coef_bank u_bank (
    .clk       (clk),
    .reset     (reset),
    .we        (w_we),
    .wr_bank   (~r_active_bank),
    .wr_addr   (w_wr_addr),
    .wr_data   (wr_data),
    .rd_bank   (r_active_bank),
    .coef_flat (coef_flat)
`ifdef SRRC_COEF_READBACK_EN
    ,
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
`endif
  );

endmodule

`default_nettype wire

// File: tb/tb_srrc_coef_bank_ctrl.sv
// ============================================================================
// Module : tb_srrc_coef_bank_ctrl
// Brief  : Self-checking bench for srrc_coef_bank_ctrl. A reference model of
//          the load / arm / swap rules tracks the visible coefficient set.
//          Honours SRRC_COEF_READBACK_EN when defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_srrc_coef_bank_ctrl;
  import srrc_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       sym_clk_en = 1'b0;
  logic                       wr_valid = 1'b0;
  logic                       wr_last = 1'b0;
  logic                       abort = 1'b0;
  logic [COEF_W-1:0]          wr_data = '0;
  logic                       wr_ready;
  logic                       active_bank;
  logic                       busy;
  logic                       swap_done;
  logic                       load_err;
  logic [COEF_W*NUM_TAPS-1:0] coef_flat;
`ifdef SRRC_COEF_READBACK_EN
  logic [CNT_W-1:0]           rd_addr = '0;
  logic [COEF_W-1:0]          rd_data;
`endif

  srrc_coef_bank_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .sym_clk_en  (sym_clk_en),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .abort       (abort),
    .coef_flat   (coef_flat),
    .active_bank (active_bank),
    .busy        (busy),
    .swap_done   (swap_done),
    .load_err    (load_err)
`ifdef SRRC_COEF_READBACK_EN
    ,
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: the set the filter sees, the set about to become visible,
  // and the words of the load in progress.
  logic [COEF_W-1:0] m_flat [NUM_TAPS];
  logic [COEF_W-1:0] m_next [NUM_TAPS];
  logic [COEF_W-1:0] m_q [$];
  bit m_pending, m_loading, m_armed, m_err, m_active, m_swap, m_ready;

  typedef struct {
    bit v; logic [COEF_W-1:0] d; bit l; bit s; bit a;
    bit e_ready; bit e_busy; bit e_swap; bit e_err; bit e_act;
  } vec_t;
  vec_t tbl [8];

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function void chk_flat(string name);
    int bad;
    bad = -1;
    for (int i = 0; i < NUM_TAPS; i++)
      if (bad < 0 && coef_flat[COEF_W*i +: COEF_W] !== m_flat[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: coef[%0d] got %0h expected %0h (cycle %0d)", name, bad,
               coef_flat[COEF_W*bad +: COEF_W], m_flat[bad], cyc);
    end
  endfunction

  function void model_reset();
    for (int i = 0; i < NUM_TAPS; i++) begin m_flat[i] = '0; m_next[i] = '0; end
    m_q.delete();
    m_pending = 0; m_loading = 0; m_armed = 0; m_err = 0;
    m_active = 0; m_swap = 0; m_ready = 0;
  endfunction

  // One clock edge of the spec's rules, applied to the inputs held at that edge.
  function void model_edge(bit v, logic [COEF_W-1:0] d, bit l, bit s, bit a);
    bit xfer, sw;
    xfer = v && m_ready;
    sw   = 0;
    if (m_pending) begin
      for (int i = 0; i < NUM_TAPS; i++) m_flat[i] = m_next[i];
      m_pending = 0;
    end
    if (m_armed) begin
      if (a) m_armed = 0;
      else if (s) begin sw = 1; m_armed = 0; end
    end else if (m_loading) begin
      if (a) begin m_loading = 0; m_q.delete(); end
      else if (xfer) begin
        m_q.push_back(d);
        if (l && m_q.size() == NUM_TAPS) begin m_loading = 0; m_armed = 1; end
        else if (l || m_q.size() == NUM_TAPS) begin m_loading = 0; m_err = 1; end
      end
    end else if (xfer) begin
      m_q.delete();
      m_q.push_back(d);
      if (l) m_err = 1;
      else begin m_err = 0; m_loading = 1; end
    end
    if (sw) begin
      m_active = ~m_active;
      for (int i = 0; i < NUM_TAPS; i++) m_next[i] = m_q[i];
      m_pending = 1;
    end
    m_swap  = sw;
    m_ready = !m_armed;
  endfunction

  task automatic check_all(string tag);
    chk({tag, "_ready"},  32'(wr_ready),    32'(m_ready));
    chk({tag, "_busy"},   32'(busy),        32'(m_loading || m_armed));
    chk({tag, "_swap"},   32'(swap_done),   32'(m_swap));
    chk({tag, "_err"},    32'(load_err),    32'(m_err));
    chk({tag, "_active"}, 32'(active_bank), 32'(m_active));
    chk_flat({tag, "_coef"});
  endtask

  task automatic step(bit v, logic [COEF_W-1:0] d, bit l, bit s, bit a);
    wr_valid = v; wr_data = d; wr_last = l; sym_clk_en = s; abort = a;
    @(posedge clk);
    model_edge(v, d, l, s, a);
    cyc++;
    @(negedge clk);
    check_all("cyc");
  endtask

  function automatic bit per_sym();
    return (cyc % 4) == 0;
  endfunction

  function automatic logic [COEF_W-1:0] gen(int kind, int i);
    if (kind == 0) return COEF_W'(i + 1);
    if (kind == 1) return (i % 2 == 0) ? 18'h1FFFF : 18'h20000;
    return COEF_W'(i * 37 + 11);
  endfunction

  task automatic stream(int n, int start, bit last_at_end, int kind);
    for (int i = 0; i < n; i++)
      step(1'b1, gen(kind, start + i), last_at_end && (i == n - 1), per_sym(), 1'b0);
  endtask

  task automatic wait_swap(int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      step(1'b0, '0, 1'b0, per_sym(), 1'b0);
      seen = swap_done;
    end
    chk("swap_within_budget", 32'(seen), 32'd1);
  endtask

  initial begin
    tbl[0] = '{1, 18'd5, 1, 0, 0,  1, 0, 0, 1, 0};
    tbl[1] = '{1, 18'd6, 0, 0, 0,  1, 1, 0, 0, 0};
    tbl[2] = '{1, 18'd7, 0, 0, 1,  1, 0, 0, 0, 0};
    tbl[3] = '{0, 18'd0, 0, 0, 1,  1, 0, 0, 0, 0};
    tbl[4] = '{1, 18'd8, 0, 0, 1,  1, 1, 0, 0, 0};
    tbl[5] = '{0, 18'd0, 0, 1, 0,  1, 1, 0, 0, 0};
    tbl[6] = '{1, 18'd9, 1, 0, 0,  1, 0, 0, 1, 0};
    tbl[7] = '{0, 18'd0, 0, 0, 0,  1, 0, 0, 1, 0};

    model_reset();
    repeat (2) @(negedge clk);
    check_all("in_reset");
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, per_sym(), 1'b0);
    chk("idle_ready", 32'(wr_ready), 32'd1);

    // Short handshake / abort table.
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].v, tbl[k].d, tbl[k].l, tbl[k].s, tbl[k].a);
      chk($sformatf("tbl%0d_ready", k), 32'(wr_ready),    32'(tbl[k].e_ready));
      chk($sformatf("tbl%0d_busy", k),  32'(busy),        32'(tbl[k].e_busy));
      chk($sformatf("tbl%0d_swap", k),  32'(swap_done),   32'(tbl[k].e_swap));
      chk($sformatf("tbl%0d_err", k),   32'(load_err),    32'(tbl[k].e_err));
      chk($sformatf("tbl%0d_act", k),   32'(active_bank), 32'(tbl[k].e_act));
    end

    // Full load of i+1, swap on a symbol boundary.
    stream(100, 0, 1'b1, 0);
    chk("full_ready_low", 32'(wr_ready), 32'd0);
    wait_swap(12);
    chk("full_active", 32'(active_bank), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("full_coef0",  32'(coef_flat[0 +: COEF_W]), 32'd1);
    chk("full_coef99", 32'(coef_flat[COEF_W*99 +: COEF_W]), 32'd100);

    // Short load, then a good load clears the error on its first word.
    stream(40, 0, 1'b1, 2);
    chk("short_err",  32'(load_err), 32'd1);
    chk("short_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, per_sym(), 1'b0);
    stream(1, 0, 1'b0, 2);
    chk("err_cleared", 32'(load_err), 32'd0);
    stream(99, 1, 1'b1, 2);
    wait_swap(12);

    // 100 words without last; word 101 starts a fresh load.
    stream(100, 0, 1'b0, 0);
    chk("nolast_err", 32'(load_err), 32'd1);
    stream(1, 0, 1'b0, 0);
    chk("word101_busy", 32'(busy), 32'd1);
    chk("word101_err",  32'(load_err), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Final word coincides with sym_clk_en: swap deferred to the next one.
    stream(99, 0, 1'b0, 0);
    step(1'b1, gen(0, 99), 1'b1, 1'b1, 1'b0);
    chk("coinc_no_swap", 32'(swap_done), 32'd0);
    wait_swap(12);
    // Abort while armed, together with sym_clk_en.
    stream(100, 0, 1'b1, 2);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("abort_no_swap", 32'(swap_done), 32'd0);
    chk("abort_busy",    32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, per_sym(), 1'b0);

    // Asynchronous reset mid-load.
    stream(50, 0, 1'b0, 2);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    stream(100, 0, 1'b1, 1);
    wait_swap(12);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("alt_coef1", 32'(coef_flat[COEF_W +: COEF_W]), 32'h20000);
`ifdef SRRC_COEF_READBACK_EN
    rd_addr = 7'd1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rd_addr1", 32'(rd_data), 32'h20000);
    rd_addr = 7'd100;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rd_oob", 32'(rd_data), 32'd0);
    rd_addr = 7'd0;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      bit v, l, s, a;
      v = $urandom_range(0, 9) < 8;
      if (m_loading && m_q.size() == NUM_TAPS - 1) l = $urandom_range(0, 9) < 9;
      else l = $urandom_range(0, 99) == 0;
      s = $urandom_range(0, 3) == 0;
      a = $urandom_range(0, 149) == 0;
      step(v, COEF_W'($urandom), l, s, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/srrc_coef_bank_ctrl.md
Name: srrc_coef_bank_ctrl

Overview:
Configuration controller for the 199-tap folded SRRC receive filter. It holds the filter's 100 unique 18-bit coefficients in two banks: an active bank driving the filter and a shadow bank accepting a streamed reload. A new set goes live only on a symbol boundary (sym_clk_en), so the filter never sees a mixed coefficient set mid-symbol. Sits between the control/host interface and the filter's coef[] inputs.

Parameters:
NUM_TAPS, 100, number of unique (folded) coefficients; index 0 = outermost tap, NUM_TAPS-1 = centre tap
COEF_W, 18, coefficient width, signed 1s17
CNT_W, 7, counter width, ceil(log2(NUM_TAPS+1))

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sym_clk_en  input  1  symbol-rate enable, one clk wide
wr_valid  input  1  coefficient stream valid
wr_ready  output  1  controller accepts wr_data this cycle
wr_data  input  COEF_W  coefficient, signed, sent in index order 0..NUM_TAPS-1
wr_last  input  1  marks final coefficient of a set
abort  input  1  discard the load in progress, one cycle
coef_flat  output  COEF_W*NUM_TAPS  active bank; coef[i] = coef_flat[COEF_W*i +: COEF_W]
active_bank  output  1  index of the bank driving coef_flat
busy  output  1  high in LOAD, ARMED
swap_done  output  1  one-cycle pulse on the cycle the banks swap
load_err  output  1  sticky length error; cleared by the next accepted first word

Behaviour:
- Reset is asynchronous, active-high; clock is clk. On reset: both banks all-zero, active_bank=0, FSM=IDLE, wr_ready=0, busy=0, swap_done=0, load_err=0, coef_flat=0. Reset mid-load discards the shadow contents.
- FSM states: IDLE, LOAD, ARMED.
- IDLE: wr_ready=1. A wr_valid&&wr_ready transfer writes shadow[0], sets cnt=1, clears load_err, and moves to LOAD. If wr_last is also set on that word (and NUM_TAPS>1), it is an error (see below).
- LOAD: wr_ready=1. Each transfer writes shadow[cnt] and increments cnt.
  - wr_last with cnt==NUM_TAPS-1 (the final word) -> ARMED.
  - wr_last early (cnt<NUM_TAPS-1) -> load_err=1, go to IDLE.
  - Final index accepted without wr_last -> load_err=1, go to IDLE.
  - The shadow bank is never made active after an error.
- ARMED: wr_ready=0. On the first sym_clk_en:
  - active_bank toggles.
  - swap_done pulses in the same cycle; coef_flat reflects the new bank from the next cycle.
  - FSM -> IDLE.
  - If sym_clk_en coincides with the final LOAD transfer, no swap occurs that cycle; the swap waits for the next sym_clk_en.
- abort: in LOAD or ARMED, returns to IDLE with no swap and no load_err. It has priority over a simultaneous transfer or sym_clk_en. Ignored in IDLE.
- coef_flat is a registered mux of bank[active_bank]. It changes only on the cycle after swap_done and is stable across every sample in a symbol.
- No arithmetic on coefficients; data is stored bit-exact.
- cnt never exceeds NUM_TAPS-1; no wrap.
- Writes always target bank[~active_bank].

Optional Feature:
SRRC_COEF_READBACK_EN
- Defined: adds input rd_addr[CNT_W-1:0] and output rd_data[COEF_W-1:0]. rd_data = active bank[rd_addr], registered, 1-cycle latency. Out-of-range addresses return 0. Reset value 0.
- Undefined: neither port exists and no readback logic is built.

Decomposition:
- Shared package srrc_pkg: COEF_W, NUM_TAPS (also used by the filter), the FSM state encoding (IDLE=2'd0, LOAD=2'd1, ARMED=2'd2), and the coef_t signed COEF_W type.
- One natural sub-module, srrc_coef_bank: a two-bank register file with write port (bank, addr, data, we), bank-select input and flattened registered read. The controller FSM, counter and handshake stay in the top.

Test Plan:
- Reset, then idle 20 cycles -> coef_flat=0, active_bank=0, wr_ready=1, busy=0, swap_done never asserted.
- Stream 100 words, value i+1 at index i, wr_last on the 100th; sym_clk_en every 4 cycles -> wr_ready=0 after the last word; on the next sym_clk_en, swap_done=1 and active_bank=1; next cycle coef[0]=1, coef[99]=100.
- Stream 40 words with wr_last on the 40th -> load_err=1, FSM IDLE, no swap_done; coef_flat unchanged. A subsequent valid load clears load_err on its first word.
- Stream 100 words without wr_last -> load_err=1 after word 100, no swap; a 101st word is accepted as the first word of a new load.
- Load completes in the same cycle as sym_clk_en -> no swap that cycle; swap on the following sym_clk_en. Assert abort while ARMED -> no swap, busy=0.
- Assert reset after 50 words are loaded -> all outputs at reset values immediately (async). After reset release, a full 100-word load of 0x1FFFF/0x20000 alternating appears bit-exact on coef_flat. With SRRC_COEF_READBACK_EN defined, rd_addr=1 gives rd_data=0x20000 one cycle later.
